// File: rtl/window_buffer.sv
// KxK sliding-window generator over a raster pixel stream.
// K-1 line buffers feed a shift window; windows are emitted only when fully inside the current frame.
module window_buffer #(
  parameter int unsigned IMG_WIDTH  = 8,
  parameter int unsigned IMG_HEIGHT = 8,
  parameter int unsigned K          = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           pixel_in,
  input  logic                 pixel_valid,
  output logic [8*K*K-1:0]     window_out,
  output logic                 window_valid,
  output logic                 frame_done
);

  localparam int unsigned PW = 8;
  localparam int unsigned NB = PW * K * K;
  localparam int unsigned CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  if (K < 2 || IMG_WIDTH < K || IMG_HEIGHT < K) begin : g_param_check
    $error("window_buffer: requires K >= 2, IMG_WIDTH >= K and IMG_HEIGHT >= K");
  end

  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [PW*(K-1)-1:0]  tap_c;
  logic [NB-1:0]        win;
  logic [NB-1:0]        win_next_c;
  logic                 col_last_c;
  logic                 row_last_c;
  logic                 in_window_c;

  always_comb begin
    col_last_c  = (col == CW'(IMG_WIDTH - 1));
    row_last_c  = (row == RW'(IMG_HEIGHT - 1));
    in_window_c = (row >= RW'(K - 1)) && (col >= CW'(K - 1));
  end

  // Raster position of the next accepted pixel; wraps per row and per frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (pixel_valid) begin
      if (col_last_c) begin
        col <= '0;
        if (row_last_c) begin
          row <= '0;
        end else begin
          row <= row + RW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffer i holds row (current - (K-1) + i); index K-2 is the most recent row.
  // Contents are never cleared: the in-window gate hides any stale row.
  for (genvar i = 0; i < int'(K) - 1; i++) begin : g_lb
    logic [PW-1:0] mem [IMG_WIDTH];

    assign tap_c[PW*i +: PW] = mem[col];

    if (i == int'(K) - 2) begin : g_newest
      always_ff @(posedge clock) begin
        if (pixel_valid) begin
          mem[col] <= pixel_in;
        end
      end
    end else begin : g_older
      always_ff @(posedge clock) begin
        if (pixel_valid) begin
          mem[col] <= tap_c[PW*(i+1) +: PW];
        end
      end
    end
  end

  // Next window: shift each row one column left, load the new right column.
  for (genvar r = 0; r < int'(K); r++) begin : g_row
    for (genvar c = 0; c < int'(K); c++) begin : g_col
      if (c < int'(K) - 1) begin : g_shift
        assign win_next_c[PW*(r*int'(K)+c) +: PW] = win[PW*(r*int'(K)+c+1) +: PW];
      end else if (r < int'(K) - 1) begin : g_from_lb
        assign win_next_c[PW*(r*int'(K)+c) +: PW] = tap_c[PW*r +: PW];
      end else begin : g_from_pixel
        assign win_next_c[PW*(r*int'(K)+c) +: PW] = pixel_in;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      win <= '0;
    end else if (pixel_valid) begin
      win <= win_next_c;
    end
  end

  // Output window only updates on a valid window so it holds between pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      window_out   <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      window_valid <= pixel_valid && in_window_c;
      frame_done   <= pixel_valid && row_last_c && col_last_c;
      if (pixel_valid && in_window_c) begin
        window_out <= win_next_c;
      end
    end
  end

endmodule

// File: tb/tb_window_buffer.sv
// Self-checking bench for window_buffer: image-array reference model, per-cycle compare, literal anchors.
module tb_window_buffer;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int K  = 4;
  localparam int NB = 8 * K * K;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic [NB-1:0] window_out;
  logic          window_valid;
  logic          frame_done;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int dones  = 0;

  always #5 clock = ~clock;

  window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .K(K)) dut (
    .clock        (clock),
    .reset        (reset),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .window_out   (window_out),
    .window_valid (window_valid),
    .frame_done   (frame_done)
  );

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: store the frame as an image and cut windows out of it.
  logic [7:0]    img [H][W];
  int            mr = 0;
  int            mc = 0;
  logic [NB-1:0] exp_win = '0;
  logic          exp_valid = 1'b0;
  logic          exp_done  = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mr = 0; mc = 0; exp_win = '0; exp_valid = 1'b0; exp_done = 1'b0;
    end else if (pixel_valid) begin
      img[mr][mc] = pixel_in;
      exp_valid = (mr >= K - 1) && (mc >= K - 1);
      exp_done  = (mr == H - 1) && (mc == W - 1);
      if (exp_valid) begin
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            exp_win[8*(i*K+j) +: 8] = img[mr-K+1+i][mc-K+1+j];
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end else begin
      exp_valid = 1'b0;
      exp_done  = 1'b0;
    end
  end

  always @(negedge clock) begin
    chk("window_valid", NB'(window_valid), NB'(exp_valid));
    chk("frame_done",   NB'(frame_done),   NB'(exp_done));
    chk("window_out",   window_out,        exp_win);
  end

  task automatic drive(input logic v, input logic [7:0] p);
    pixel_valid = v;
    pixel_in    = p;
    @(posedge clock);
    #1;
    if (window_valid) pulses++;
    if (frame_done)   dones++;
  endtask

  function automatic logic [7:0] byte_at(input logic [NB-1:0] w, input int idx);
    return w[8*idx +: 8];
  endfunction

  // mode 0: row*W+col, mode 1: constant 3, mode 2: random pixels.
  task automatic send_frame(input int mode, input int gap_pct, input int npix, input bit lit);
    int n = 0;
    int mac;
    logic [7:0] p;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n >= npix) return;
        for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++)
          drive(1'b0, 8'($urandom));
        p = (mode == 0) ? 8'(r * W + c) : (mode == 1) ? 8'd3 : 8'($urandom);
        drive(1'b1, p);
        n++;
        if (lit && mode == 0) begin
          if (r == 3 && c == 2) chk("no_pulse_before_28", NB'(window_valid), NB'(0));
          if (r == 3 && c == 3) begin
            chk("first_valid", NB'(window_valid), NB'(1));
            chk("first_b0",  NB'(byte_at(window_out, 0)),  NB'(0));
            chk("first_b3",  NB'(byte_at(window_out, 3)),  NB'(3));
            chk("first_b12", NB'(byte_at(window_out, 12)), NB'(24));
            chk("first_b15", NB'(byte_at(window_out, 15)), NB'(27));
            chk("model_first_b15", NB'(byte_at(exp_win, 15)), NB'(27));
          end
          if (r == H - 1 && c == W - 1) begin
            chk("last_valid", NB'(window_valid), NB'(1));
            chk("last_done",  NB'(frame_done),   NB'(1));
            chk("last_b0",  NB'(byte_at(window_out, 0)),  NB'(36));
            chk("last_b15", NB'(byte_at(window_out, 15)), NB'(63));
          end
        end
        if (mode == 1 && r == H - 1 && c == W - 1) begin
          mac = 0;
          for (int i = 0; i < K * K; i++) mac += 2 * int'(byte_at(window_out, i));
          chk("all3_window", window_out, {(K*K){8'd3}});
          chk("mac_all2_kernel", NB'(mac), NB'(96));
        end
      end
    end
  endtask

  task automatic frame_counts(input string name);
    chk({name, "_pulses"}, NB'(pulses), NB'(25));
    chk({name, "_dones"},  NB'(dones),  NB'(1));
    pulses = 0;
    dones  = 0;
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'($urandom), 8'($urandom));
    chk("rst_window_out", window_out, '0);
    chk("rst_valid", NB'(window_valid), NB'(0));
    chk("rst_done",  NB'(frame_done),   NB'(0));
    reset = 1'b1;
    pulses = 0;
    dones  = 0;
    drive(1'b0, 8'h00);

    send_frame(0, 0, W * H, 1'b1);
    frame_counts("frame_seq");
    send_frame(1, 0, W * H, 1'b0);
    frame_counts("frame_all3");
    send_frame(0, 30, W * H, 1'b1);
    frame_counts("frame_gaps");

    send_frame(0, 0, 41, 1'b0);
    reset = 1'b0;
    pulses = 0;
    dones  = 0;
    for (int i = 0; i < 3; i++) drive(1'($urandom), 8'($urandom));
    chk("midrst_valid", NB'(window_valid), NB'(0));
    chk("midrst_out", window_out, '0);
    reset = 1'b1;
    drive(1'b0, 8'h00);
    chk("midrst_pulses", NB'(pulses), NB'(0));
    send_frame(0, 0, W * H, 1'b1);
    frame_counts("frame_after_rst");

    send_frame(2, 40, W * H, 1'b0);
    frame_counts("frame_random");
    send_frame(2, 0, W * H, 1'b0);
    frame_counts("frame_random_b2b");
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
